// File: rtl/osm_txq_pkg.sv
// Shared constants and helpers for the OSM NPI-to-SATA transmit queue.
// Holds the queued entry layout, burst sizing and debug-word bit positions.
package osm_txq_pkg;

  localparam int unsigned C_BURST_QW   = 16;
  localparam int unsigned C_RDY_MARGIN = 16;
  localparam int unsigned ENTRY_W      = 66;

  localparam int unsigned DBG_PHASE = 16;
  localparam int unsigned DBG_RDY   = 17;
  localparam int unsigned DBG_OVF   = 18;
  localparam int unsigned DBG_TXV   = 30;
  localparam int unsigned DBG_TXR   = 31;

  typedef struct packed {
    logic        rem;
    logic        last;
    logic [63:0] data;
  } txqEntry_t;

  function automatic logic [31:0] dwordSel(input txqEntry_t e, input logic hi);
    return hi ? e.data[63:32] : e.data[31:0];
  endfunction

endpackage

// File: rtl/osm_txq_ram.sv
// Simple dual-port storage for the transmit queue: one synchronous write
// port and one asynchronous read port, no reset on the array.
module osm_txq_ram #(
  parameter int C_AW = 6,
  parameter int C_W  = 66
) (
  input  logic            sys_clk,
  input  logic            wrEn,
  input  logic [C_AW-1:0] wrAddr,
  input  logic [C_W-1:0]  wrData,
  input  logic [C_AW-1:0] rdAddr,
  output logic [C_W-1:0]  rdData
);

  logic [C_W-1:0] mem [0:(1<<C_AW)-1];

  // Write port.
  always_ff @(posedge sys_clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/osm_txq.sv
// NPI read-data to SATA transport TX queue: buffers 64-bit qwords and
// emits them as 32-bit dwords in first-word-fall-through order.
module osm_txq
  import osm_txq_pkg::*;
#(
  parameter int C_AW       = 6,
  parameter int C_RDY_FREE = int'(C_BURST_QW + C_RDY_MARGIN)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] npi_data,
  input  logic        npi_valid,
  input  logic        npi_last,
  input  logic        npi_rem,
  output logic        npi_rdy,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic        tx_flush,
  output logic        txq_ovf,
  output logic [31:0] osm_txq2dbg
);

  localparam logic [C_AW:0] DEPTH_V    = {1'b1, {C_AW{1'b0}}};
  localparam logic [C_AW:0] ZERO_V     = {(C_AW+1){1'b0}};
  localparam logic [C_AW:0] RDY_FREE_V = C_RDY_FREE[C_AW:0];

  logic [C_AW:0] wrPtrQ, rdPtrQ, occQ;
  logic [C_AW:0] wrPtrNxt, rdPtrNxt, occNxt, occAfterPop;
  logic          phaseQ, phaseNxt;
  logic          headLastQ, headRemQ;
  logic          ovfQ, npiRdyQ, txValidQ, txLastQ;
  logic [31:0]   txDataQ;

  logic          full, wrEn, xfer, headPair, popEn;
  txqEntry_t     wrEntry, rdEntry, headNxt;
  logic [ENTRY_W-1:0] rdRaw;

  assign full     = (occQ == DEPTH_V);
  assign wrEn     = npi_valid & ~full & ~tx_flush;
  assign xfer     = txValidQ & tx_ready;
  assign headPair = headLastQ & headRemQ;
  assign popEn    = xfer & (phaseQ | headPair) & ~tx_flush;

  assign wrEntry.rem  = npi_last & npi_rem;
  assign wrEntry.last = npi_last;
  assign wrEntry.data = npi_data;
  assign rdEntry      = txqEntry_t'(rdRaw);

  osm_txq_ram #(
    .C_AW (C_AW),
    .C_W  (ENTRY_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .wrEn    (wrEn),
    .wrAddr  (wrPtrQ[C_AW-1:0]),
    .wrData  (wrEntry),
    .rdAddr  (rdPtrNxt[C_AW-1:0]),
    .rdData  (rdRaw)
  );

  // Pointer, occupancy and dword-phase next state; flush overrides everything.
  always_comb begin
    wrPtrNxt = wrPtrQ;
    rdPtrNxt = rdPtrQ;
    occNxt   = occQ;
    phaseNxt = phaseQ;
    if (tx_flush) begin
      wrPtrNxt = ZERO_V;
      rdPtrNxt = ZERO_V;
      occNxt   = ZERO_V;
      phaseNxt = 1'b0;
    end else begin
      wrPtrNxt = wrPtrQ + (C_AW+1)'(wrEn);
      rdPtrNxt = rdPtrQ + (C_AW+1)'(popEn);
      occNxt   = occQ + (C_AW+1)'(wrEn) - (C_AW+1)'(popEn);
      if (xfer) begin
        phaseNxt = ~phaseQ & ~headPair;
      end else begin
        phaseNxt = phaseQ;
      end
    end
  end

  // Next head entry; a qword landing in an otherwise empty queue bypasses the RAM.
  always_comb begin
    occAfterPop = occQ - (C_AW+1)'(popEn);
    if (wrEn && (occAfterPop == ZERO_V)) begin
      headNxt = wrEntry;
    end else begin
      headNxt = rdEntry;
    end
  end

  // Queue state and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wrPtrQ    <= ZERO_V;
      rdPtrQ    <= ZERO_V;
      occQ      <= ZERO_V;
      phaseQ    <= 1'b0;
      headLastQ <= 1'b0;
      headRemQ  <= 1'b0;
      ovfQ      <= 1'b0;
      npiRdyQ   <= 1'b0;
      txValidQ  <= 1'b0;
      txLastQ   <= 1'b0;
      txDataQ   <= 32'd0;
    end else begin
      wrPtrQ    <= wrPtrNxt;
      rdPtrQ    <= rdPtrNxt;
      occQ      <= occNxt;
      phaseQ    <= phaseNxt;
      headLastQ <= headNxt.last;
      headRemQ  <= headNxt.rem;
      ovfQ      <= ovfQ | (npi_valid & full & ~tx_flush);
      npiRdyQ   <= ((DEPTH_V - occNxt) >= RDY_FREE_V);
      txValidQ  <= (occNxt != ZERO_V);
      txLastQ   <= (occNxt != ZERO_V) & headNxt.last & (phaseNxt | headNxt.rem);
      txDataQ   <= dwordSel(headNxt, phaseNxt);
    end
  end

  // Debug word assembly.
  always_comb begin
    osm_txq2dbg            = 32'd0;
    osm_txq2dbg[C_AW:0]    = occQ;
    osm_txq2dbg[DBG_PHASE] = phaseQ;
    osm_txq2dbg[DBG_RDY]   = npiRdyQ;
    osm_txq2dbg[DBG_OVF]   = ovfQ;
    osm_txq2dbg[DBG_TXV]   = txValidQ;
    osm_txq2dbg[DBG_TXR]   = tx_ready;
  end

  assign npi_rdy  = npiRdyQ;
  assign tx_data  = txDataQ;
  assign tx_valid = txValidQ;
  assign tx_last  = txLastQ;
  assign txq_ovf  = ovfQ;

endmodule

// File: tb/tb_osm_txq.sv
// Self-checking bench for osm_txq: queue-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_osm_txq;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [63:0] npi_data = 64'd0;
  logic        npi_valid = 1'b0, npi_last = 1'b0, npi_rem = 1'b0;
  logic        tx_ready = 1'b0, tx_flush = 1'b0;
  logic        npi_rdy, tx_valid, tx_last, txq_ovf;
  logic [31:0] tx_data, osm_txq2dbg;

  always #5 sys_clk = ~sys_clk;

  osm_txq dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .npi_data    (npi_data),
    .npi_valid   (npi_valid),
    .npi_last    (npi_last),
    .npi_rem     (npi_rem),
    .npi_rdy     (npi_rdy),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .tx_flush    (tx_flush),
    .txq_ovf     (txq_ovf),
    .osm_txq2dbg (osm_txq2dbg)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        r;
  } ent_t;

  ent_t        mq[$];
  bit          mPhase = 1'b0, mOvf = 1'b0, mRdy = 1'b0;
  int          errors = 0, checks = 0, cyc = 0;
  logic [31:0] logD[$];
  bit          logL[$];
  int          logC[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic put(input logic v, input logic [63:0] d, input logic l, input logic r);
    npi_valid = v;
    npi_data  = d;
    npi_last  = l;
    npi_rem   = r;
  endtask

  // Queue-level reference: transfers take dwords from the head qword, writes append.
  task automatic modelUpdate();
    bit popIt;
    bit fullPre;
    popIt   = 1'b0;
    fullPre = (mq.size() == 64);
    if (tx_flush) begin
      mq.delete();
      mPhase = 1'b0;
    end else begin
      if (mq.size() != 0 && tx_ready) begin
        if (mPhase) begin
          popIt  = 1'b1;
          mPhase = 1'b0;
        end else if (mq[0].l && mq[0].r) begin
          popIt = 1'b1;
        end else begin
          mPhase = 1'b1;
        end
      end
      if (npi_valid) begin
        if (fullPre) mOvf = 1'b1;
        else mq.push_back('{npi_data, npi_last, npi_last & npi_rem});
      end
      if (popIt) void'(mq.pop_front());
    end
    mRdy = ((64 - mq.size()) >= 32);
  endtask

  task automatic modelCheck();
    logic        expV;
    logic [31:0] expDbg;
    expV   = (mq.size() != 0);
    expDbg = 32'd0;
    expDbg[6:0] = 7'(mq.size());
    expDbg[16]  = mPhase;
    expDbg[17]  = mRdy;
    expDbg[18]  = mOvf;
    expDbg[30]  = expV;
    expDbg[31]  = tx_ready;
    chk("tx_valid", {63'd0, tx_valid}, {63'd0, expV});
    if (expV) begin
      chk("tx_data", {32'd0, tx_data}, {32'd0, mPhase ? mq[0].d[63:32] : mq[0].d[31:0]});
      chk("tx_last", {63'd0, tx_last}, {63'd0, mq[0].l & (mPhase | mq[0].r)});
    end
    chk("npi_rdy", {63'd0, npi_rdy}, {63'd0, mRdy});
    chk("txq_ovf", {63'd0, txq_ovf}, {63'd0, mOvf});
    chk("dbg", {32'd0, osm_txq2dbg}, {32'd0, expDbg});
  endtask

  // Called at a negedge with inputs set; advances one clock and checks.
  task automatic step();
    if (tx_valid && tx_ready && !tx_flush) begin
      logD.push_back(tx_data);
      logL.push_back(tx_last);
      logC.push_back(cyc);
    end
    @(posedge sys_clk);
    modelUpdate();
    cyc++;
    @(negedge sys_clk);
    modelCheck();
  endtask

  task automatic clearLog();
    logD.delete();
    logL.delete();
    logC.delete();
  endtask

  task automatic resetAt();
    sys_rst = 1'b1;
    #1;
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_last", {63'd0, tx_last}, 64'd0);
    chk("rst_npi_rdy", {63'd0, npi_rdy}, 64'd0);
    chk("rst_txq_ovf", {63'd0, txq_ovf}, 64'd0);
    mq.delete();
    mPhase = 1'b0;
    mOvf   = 1'b0;
    mRdy   = 1'b0;
    put(1'b0, 64'd0, 1'b0, 1'b0);
    tx_ready = 1'b0;
    tx_flush = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    modelCheck();
    sys_rst = 1'b0;
    clearLog();
    step();
    chk("rdy_after_reset", {63'd0, npi_rdy}, 64'd1);
  endtask

  initial begin
    logic [63:0] qa, qb, qc, qd, qe, qf;
    int pv, pr;
    qa = 64'hA1A1A1A1_A0A0A0A0;
    qb = 64'hB1B1B1B1_B0B0B0B0;
    qc = 64'hC1C1C1C1_C0C0C0C0;
    qd = 64'hDDDD1111_D0D0D0D0;
    qe = 64'hE1E1E1E1_E0E0E0E0;
    qf = 64'hF1F1F1F1_F0F0F0F0;
    #2;
    resetAt();

    // Three qwords streamed back-to-back as six dwords.
    tx_ready = 1'b1;
    put(1'b1, qa, 1'b0, 1'b0); step();
    put(1'b1, qb, 1'b0, 1'b0); step();
    put(1'b1, qc, 1'b1, 1'b0); step();
    put(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (6) step();
    chk("s36_count", 64'(logD.size()), 64'd6);
    if (logD.size() == 6) begin
      chk("s36_d0", {32'd0, logD[0]}, 64'hA0A0A0A0);
      chk("s36_d1", {32'd0, logD[1]}, 64'hA1A1A1A1);
      chk("s36_d2", {32'd0, logD[2]}, 64'hB0B0B0B0);
      chk("s36_d3", {32'd0, logD[3]}, 64'hB1B1B1B1);
      chk("s36_d4", {32'd0, logD[4]}, 64'hC0C0C0C0);
      chk("s36_d5", {32'd0, logD[5]}, 64'hC1C1C1C1);
      for (int i = 0; i < 6; i++) begin
        chk("s36_last", {63'd0, logL[i]}, (i == 5) ? 64'd1 : 64'd0);
        chk("s36_consec", 64'(logC[i] - logC[0]), 64'(i));
      end
    end

    // Single qword with rem: one dword only.
    clearLog();
    put(1'b1, qd, 1'b1, 1'b1); step();
    put(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (2) step();
    chk("s37_count", 64'(logD.size()), 64'd1);
    if (logD.size() == 1) begin
      chk("s37_data", {32'd0, logD[0]}, 64'hD0D0D0D0);
      chk("s37_last", {63'd0, logL[0]}, 64'd1);
    end
    chk("s37_occ", {57'd0, osm_txq2dbg[6:0]}, 64'd0);

    // npi_rdy threshold around occupancy 32/33.
    tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      put(1'b1, {32'(i), 32'(i + 1000)}, 1'b0, 1'b0); step();
    end
    chk("s38_rdy32", {63'd0, npi_rdy}, 64'd1);
    put(1'b1, 64'h33, 1'b0, 1'b0); step();
    chk("s38_rdy33", {63'd0, npi_rdy}, 64'd0);
    put(1'b0, 64'd0, 1'b0, 1'b0);
    tx_ready = 1'b1;
    step();
    chk("s38_rdy_half", {63'd0, npi_rdy}, 64'd0);
    step();
    chk("s38_rdy_back", {63'd0, npi_rdy}, 64'd1);
    repeat (64) step();
    chk("s38_drained", {63'd0, tx_valid}, 64'd0);

    // Overflow: 65 writes into an empty queue with no reads.
    tx_ready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      put(1'b1, {32'hABCD0000, 32'(i)}, 1'b0, 1'b0); step();
    end
    put(1'b0, 64'd0, 1'b0, 1'b0);
    chk("s39_occ", {57'd0, osm_txq2dbg[6:0]}, 64'd64);
    chk("s39_ovf", {63'd0, txq_ovf}, 64'd1);
    tx_flush = 1'b1; step(); tx_flush = 1'b0;
    chk("s39_ovf_flush", {63'd0, txq_ovf}, 64'd1);
    chk("s39_occ_flush", {57'd0, osm_txq2dbg[6:0]}, 64'd0);

    // Flush while presenting dword1 of the head.
    resetAt();
    for (int i = 0; i < 5; i++) begin
      put(1'b1, {32'h55550000, 32'(i)}, 1'b0, 1'b0); step();
    end
    put(1'b0, 64'd0, 1'b0, 1'b0);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("s40_phase1", {63'd0, osm_txq2dbg[16]}, 64'd1);
    tx_flush = 1'b1; step(); tx_flush = 1'b0;
    chk("s40_valid", {63'd0, tx_valid}, 64'd0);
    chk("s40_occ", {57'd0, osm_txq2dbg[6:0]}, 64'd0);
    chk("s40_phase", {63'd0, osm_txq2dbg[16]}, 64'd0);
    clearLog();
    tx_ready = 1'b1;
    put(1'b1, qe, 1'b1, 1'b0); step();
    put(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk("s40_count", 64'(logD.size()), 64'd2);
    if (logD.size() >= 1) chk("s40_first", {32'd0, logD[0]}, 64'hE0E0E0E0);

    // Randomized traffic with varying fill/drain pressure and rare flushes.
    for (int seg = 0; seg < 40; seg++) begin
      pv = $urandom_range(0, 100);
      pr = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        put(($urandom_range(0, 99) < pv), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        tx_ready = ($urandom_range(0, 99) < pr);
        tx_flush = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    tx_flush = 1'b0;

    // Asynchronous reset in the middle of a stream with tx_ready toggling.
    for (int c = 0; c < 20; c++) begin
      put(1'b1, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'b0);
      tx_ready = ~tx_ready;
      step();
    end
    #2;
    resetAt();
    tx_ready = 1'b1;
    put(1'b1, qf, 1'b1, 1'b0); step();
    put(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk("s41_count", 64'(logD.size()), 64'd2);
    if (logD.size() >= 1) chk("s41_first", {32'd0, logD[0]}, 64'hF0F0F0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osm_txq.md
OSM_TXQ -- requirements
Module: osm_txq

Interface
REQ-001 Parameter C_AW, default 6, log2 of FIFO depth in 64-bit entries (depth 64).
REQ-002 Parameter C_RDY_FREE, default 32, minimum free entries for npi_rdy.
REQ-003 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 npi_data  in  64  read-data qword; dword0 = [31:0], dword1 = [63:32].
REQ-006 npi_valid  in  1  qword strobe, one entry per asserted cycle, no backpressure.
REQ-007 npi_last  in  1  qualifies final qword of the transfer; meaningful only with npi_valid.
REQ-008 npi_rem  in  1  with npi_last: only dword0 of the final qword is valid.
REQ-009 npi_rdy  out  1  space for a full 16-qword burst plus pipeline margin.
REQ-010 tx_data  out  32  dword toward the SATA transport TX path.
REQ-011 tx_valid  out  1  tx_data valid.
REQ-012 tx_last  out  1  final dword of the transfer.
REQ-013 tx_ready  in  1  downstream accepts when high with tx_valid.
REQ-014 tx_flush  in  1  synchronous discard of all contents (command abort).
REQ-015 txq_ovf  out  1  sticky overflow error.
REQ-016 osm_txq2dbg  out  32  debug: [C_AW:0] occupancy, [16] phase, [17] npi_rdy, [18] txq_ovf, [30] tx_valid, [31] tx_ready; other bits 0.

Function
REQ-017 Storage: 2^C_AW entries of 66 bits {rem, last, data}; write pointer, read pointer, and occupancy counter each C_AW+1 bits wide; occupancy counts 0..2^C_AW.
REQ-018 Write: npi_valid with occupancy < 2^C_AW and no flush -> store entry; pointer wraps modulo 2^C_AW.
REQ-019 Write while full -> entry dropped, txq_ovf set and held until reset.
REQ-020 npi_rem stored as 0 unless npi_last is also 1.
REQ-021 Read is first-word-fall-through: tx_valid = (occupancy != 0); a qword written at edge N shows tx_valid after edge N.
REQ-022 Phase bit: phase 0 presents dword0, phase 1 presents dword1 of the head entry.
REQ-023 Transfer (tx_valid & tx_ready) in phase 0: if head last&rem -> pop, phase stays 0; else phase -> 1, no pop.
REQ-024 Transfer in phase 1 -> pop, phase -> 0.
REQ-025 tx_last = head.last & (phase 1, or phase 0 with head.rem).
REQ-026 tx_data, tx_last: don't-care when tx_valid is 0; stable while tx_valid & ~tx_ready.
REQ-027 Simultaneous write and pop -> occupancy unchanged; both pointers advance.
REQ-028 npi_rdy registered: next value = (2^C_AW - next occupancy) >= C_RDY_FREE.
REQ-029 tx_flush -> pointers, occupancy and phase cleared next edge; a same-cycle write or pop is ignored; txq_ovf unaffected.
REQ-030 Packets are not reordered or merged; consecutive transfers stream back-to-back.

Reset
REQ-031 sys_rst asserted -> immediately: pointers 0, occupancy 0, phase 0, txq_ovf 0, npi_rdy 0, tx_valid 0, tx_last 0.
REQ-032 After deassert, npi_rdy rises at the first clock edge (empty FIFO).
REQ-033 Reset mid-transfer discards all data; no partial dword is emitted afterwards.

Structure
REQ-034 Shared package: 16-qword burst constant, debug bit-position constants.
REQ-035 One sub-module: osm_txq_ram, a simple dual-port 66 x 2^C_AW memory with asynchronous read; control logic stays in osm_txq.

Verification
REQ-036 3 qwords {A,B,C}, last on C, rem 0, tx_ready 1 -> 6 dwords A0,A1,B0,B1,C0,C1 on consecutive cycles; tx_last only on C1.
REQ-037 1 qword D, last=1, rem=1 -> single dword D[31:0] with tx_last 1; occupancy returns to 0 after 1 transfer.
REQ-038 tx_ready held 0 while 33 qwords written -> npi_rdy falls once free < 32 (occupancy 33); after draining, npi_rdy rises again when free >= 32.
REQ-039 65 consecutive npi_valid into empty FIFO with tx_ready 0 -> occupancy 64, 65th qword dropped, txq_ovf 1 and stays 1 after tx_flush.
REQ-040 tx_flush asserted in phase 1 with 5 entries -> next cycle tx_valid 0, occupancy 0, phase 0; a following qword E emits E0 first.
REQ-041 sys_rst asserted mid-stream with tx_ready toggling -> outputs take reset values without waiting for a clock; post-reset stream begins with the next written qword's dword0.
